// File: rtl/morra_match_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morra_match_sequencer_if
//  Description : Player move channels and Morracinese core connection used
//                by morra_match_sequencer.
//                master : sequencer side (drives readies and core inputs)
//                slave  : environment side (players and game core)
//  Signals     : p1_valid/p1_move/p1_ready, p2_valid/p2_move/p2_ready,
//                core_reset, core_g1, core_g2, core_manche, core_partita
//  Revision    : 1.0 - initial release
// ============================================================================
interface morra_match_sequencer_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic       core_reset;
  logic [1:0] core_g1;
  logic [1:0] core_g2;
  logic [1:0] core_manche;
  logic [1:0] core_partita;

  modport master (
    input  p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita,
    output p1_ready, p2_ready, core_reset, core_g1, core_g2
  );

  modport slave (
    output p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita,
    input  p1_ready, p2_ready, core_reset, core_g1, core_g2
  );
endinterface
`default_nettype wire

// File: rtl/morra_match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morra_match_sequencer
//  Description : Sequences one match on the Morracinese game core. Collects
//                one move per player, issues the pair to the core for one
//                cycle, samples round/match results, keeps round and win
//                counters and pulses done with the match result.
//  Ports       : clk, reset (async, active-low), start, abort, max_cfg[3:0],
//                bus (morra_match_sequencer_if.master: player channels and
//                core connection), busy, done, result[1:0],
//                rounds/wins_p1/wins_p2[CNT_W-1:0]
//  Options     : `define MORRA_TIMEOUT_EN enables the COLLECT stall timeout
//                (TIMEOUT_CYC cycles) with forfeit of the silent player.
//  Revision    : 1.0 - initial release
// ============================================================================
module morra_match_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 5
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             abort,
  input  wire logic [3:0]       max_cfg,
  morra_match_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result,
  output logic [CNT_W-1:0]      rounds,
  output logic [CNT_W-1:0]      wins_p1,
  output logic [CNT_W-1:0]      wins_p2
);

  if (TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_param_check
    $error("morra_match_sequencer: TIMEOUT_CYC and CNT_W must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG     = 3'd1,
    S_COLLECT = 3'd2,
    S_ISSUE   = 3'd3,
    S_SAMPLE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             p1_held_q, p1_held_d, p2_held_q, p2_held_d;
  logic [1:0]       p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
  logic [1:0]       result_q, result_d;
  logic [CNT_W-1:0] rounds_q, rounds_d, wins_p1_q, wins_p1_d, wins_p2_q, wins_p2_d;
  logic             core_reset_q, core_reset_d;
  logic [1:0]       core_g1_q, core_g1_d, core_g2_q, core_g2_d;
  logic             busy_q, done_q;

  logic             p1_legal, p2_legal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Illegal (00) moves complete the handshake but are not held.
  assign p1_legal = (state_q == S_COLLECT) && !p1_held_q && bus.p1_valid && (bus.p1_move != 2'b00);
  assign p2_legal = (state_q == S_COLLECT) && !p2_held_q && bus.p2_valid && (bus.p2_move != 2'b00);

`ifdef MORRA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            to_hit;

  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if (state_q == S_COLLECT && !(p1_legal || p2_legal)) begin
      to_d   = to_q + TO_W'(1);
      to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    p1_held_d = p1_held_q;
    p2_held_d = p2_held_q;
    p1_mv_d   = p1_mv_q;
    p2_mv_d   = p2_mv_q;
    result_d  = result_q;
    rounds_d  = rounds_q;
    wins_p1_d = wins_p1_q;
    wins_p2_d = wins_p2_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_CFG;
          rounds_d  = '0;
          wins_p1_d = '0;
          wins_p2_d = '0;
        end
      end
      S_CFG: state_d = S_COLLECT;
      S_COLLECT: begin
        if (p1_legal) begin
          p1_held_d = 1'b1;
          p1_mv_d   = bus.p1_move;
        end
        if (p2_legal) begin
          p2_held_d = 1'b1;
          p2_mv_d   = bus.p2_move;
        end
        if (p1_held_d && p2_held_d) begin
          state_d = S_ISSUE;
        end
`ifdef MORRA_TIMEOUT_EN
        else if (to_hit) begin
          // The silent player forfeits; nobody moved means a draw.
          state_d  = S_DONE;
          result_d = p1_held_q ? 2'b01 : (p2_held_q ? 2'b10 : 2'b11);
        end
`endif
      end
      S_ISSUE: begin
        p1_held_d = 1'b0;
        p2_held_d = 1'b0;
        state_d   = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.core_manche != 2'b00) rounds_d = sat_inc(rounds_q);
        if (bus.core_manche == 2'b01) wins_p1_d = sat_inc(wins_p1_q);
        if (bus.core_manche == 2'b10) wins_p2_d = sat_inc(wins_p2_q);
        if (bus.core_partita != 2'b00) begin
          result_d = bus.core_partita;
          state_d  = S_DONE;
        end else begin
          state_d  = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort cancels the match without touching result or counters.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      p1_held_d = 1'b0;
      p2_held_d = 1'b0;
      result_d  = result_q;
      rounds_d  = rounds_q;
      wins_p1_d = wins_p1_q;
      wins_p2_d = wins_p2_q;
    end
  end

  // Core-facing outputs are registered, decoded from the next state.
  always_comb begin
    core_reset_d = (state_d == S_IDLE) || (state_d == S_CFG);
`ifdef MORRA_TIMEOUT_EN
    if (state_d == S_DONE) core_reset_d = 1'b1;
`endif
    core_g1_d = 2'b00;
    core_g2_d = 2'b00;
    if (state_d == S_CFG) begin
      core_g1_d = max_cfg[3:2];
      core_g2_d = max_cfg[1:0];
    end else if (state_d == S_ISSUE) begin
      core_g1_d = p1_mv_d;
      core_g2_d = p2_mv_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      p1_held_q    <= 1'b0;
      p2_held_q    <= 1'b0;
      p1_mv_q      <= 2'b00;
      p2_mv_q      <= 2'b00;
      result_q     <= 2'b00;
      rounds_q     <= '0;
      wins_p1_q    <= '0;
      wins_p2_q    <= '0;
      core_reset_q <= 1'b1;
      core_g1_q    <= 2'b00;
      core_g2_q    <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_held_q    <= p1_held_d;
      p2_held_q    <= p2_held_d;
      p1_mv_q      <= p1_mv_d;
      p2_mv_q      <= p2_mv_d;
      result_q     <= result_d;
      rounds_q     <= rounds_d;
      wins_p1_q    <= wins_p1_d;
      wins_p2_q    <= wins_p2_d;
      core_reset_q <= core_reset_d;
      core_g1_q    <= core_g1_d;
      core_g2_q    <= core_g2_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.p1_ready   = (state_q == S_COLLECT) && !p1_held_q;
  assign bus.p2_ready   = (state_q == S_COLLECT) && !p2_held_q;
  assign bus.core_reset = core_reset_q;
  assign bus.core_g1    = core_g1_q;
  assign bus.core_g2    = core_g2_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign rounds         = rounds_q;
  assign wins_p1        = wins_p1_q;
  assign wins_p2        = wins_p2_q;

endmodule
`default_nettype wire

// File: tb/tb_morra_match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morra_match_sequencer
//  Description : Directed self-checking bench for morra_match_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morra_match_sequencer;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       max_cfg = 4'h0;
  logic             busy, done;
  logic [1:0]       result;
  logic [CNT_W-1:0] rounds, wins_p1, wins_p2;

  int n_chk = 0;
  int n_err = 0;

  morra_match_sequencer_if bus ();

  morra_match_sequencer #(.TIMEOUT_CYC(8), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .max_cfg (max_cfg),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rounds  (rounds),
    .wins_p1 (wins_p1),
    .wins_p2 (wins_p2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a match; returns with the DUT in COLLECT.
  task automatic do_start(input logic [3:0] cfg);
    start   = 1'b1;
    max_cfg = cfg;
    tick();
    start = 1'b0;
    chk("cfg_core_reset", 32'(bus.core_reset), 32'd1);
    chk("cfg_g1", 32'(bus.core_g1), 32'(cfg[3:2]));
    chk("cfg_g2", 32'(bus.core_g2), 32'(cfg[1:0]));
    chk("cfg_busy", 32'(busy), 32'd1);
    tick();
    chk("collect_core_reset", 32'(bus.core_reset), 32'd0);
  endtask

  // Both players move in the same cycle; returns one cycle after SAMPLE.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2,
                      input logic [1:0] manche, input logic [1:0] partita);
    bus.core_manche  = manche;
    bus.core_partita = partita;
    bus.p1_valid = 1'b1; bus.p1_move = m1;
    bus.p2_valid = 1'b1; bus.p2_move = m2;
    tick();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    chk("issue_g1", 32'(bus.core_g1), 32'(m1));
    chk("issue_g2", 32'(bus.core_g2), 32'(m2));
    tick();
    chk("sample_g1", 32'(bus.core_g1), 32'd0);
    tick();
  endtask

  initial begin
    bit saw_done;
    bus.p1_valid = 1'b0; bus.p1_move = 2'b00;
    bus.p2_valid = 1'b0; bus.p2_move = 2'b00;
    bus.core_manche = 2'b00; bus.core_partita = 2'b00;

    // Reset state
    repeat (3) tick();
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_g1", 32'(bus.core_g1), 32'd0);
    chk("rst_g2", 32'(bus.core_g2), 32'd0);
    chk("rst_p1_ready", 32'(bus.p1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_rounds", 32'(rounds), 32'd0);
    reset = 1'b1;
    tick();

    // P2 wins four rounds of a 4-round match
    do_start(4'b0000);
    chk("collect_p1_ready", 32'(bus.p1_ready), 32'd1);
    chk("collect_p2_ready", 32'(bus.p2_ready), 32'd1);
    for (int i = 0; i < 3; i++) play(2'b01, 2'b10, 2'b10, 2'b00);
    chk("r3_rounds", 32'(rounds), 32'd3);
    chk("r3_wins_p2", 32'(wins_p2), 32'd3);
    chk("r3_done", 32'(done), 32'd0);
    chk("r3_back_collect", 32'(bus.p1_ready), 32'd1);
    play(2'b01, 2'b10, 2'b10, 2'b10);
    chk("m_done", 32'(done), 32'd1);
    chk("m_result", 32'(result), 32'd2);
    chk("m_rounds", 32'(rounds), 32'd4);
    chk("m_wins_p2", 32'(wins_p2), 32'd4);
    chk("m_wins_p1", 32'(wins_p1), 32'd0);
    tick();
    chk("m_done_pulse", 32'(done), 32'd0);
    chk("m_idle_busy", 32'(busy), 32'd0);
    chk("m_hold_rounds", 32'(rounds), 32'd4);

    // Illegal move discarded, legal move held
    do_start(4'b0110);
    chk("s2_rounds_clr", 32'(rounds), 32'd0);
    chk("s2_wins_clr", 32'(wins_p2), 32'd0);
    bus.p1_valid = 1'b1; bus.p1_move = 2'b00;
    tick();
    chk("illegal_ready_high", 32'(bus.p1_ready), 32'd1);
    bus.p1_move = 2'b01;
    tick();
    bus.p1_valid = 1'b0;
    chk("legal_ready_low", 32'(bus.p1_ready), 32'd0);
    chk("legal_rounds_same", 32'(rounds), 32'd0);
    bus.core_manche = 2'b01; bus.core_partita = 2'b00;
    bus.p2_valid = 1'b1; bus.p2_move = 2'b11;
    tick();
    bus.p2_valid = 1'b0;
    chk("held_issue_g1", 32'(bus.core_g1), 32'd1);
    chk("held_issue_g2", 32'(bus.core_g2), 32'd3);
    tick(); tick();
    chk("p1win_rounds", 32'(rounds), 32'd1);
    chk("p1win_wins_p1", 32'(wins_p1), 32'd1);

    // Invalid round and drawn round
    play(2'b10, 2'b10, 2'b00, 2'b00);
    chk("inv_rounds", 32'(rounds), 32'd1);
    chk("inv_collect", 32'(bus.p1_ready), 32'd1);
    play(2'b11, 2'b11, 2'b11, 2'b00);
    chk("draw_rounds", 32'(rounds), 32'd2);
    chk("draw_wins_p1", 32'(wins_p1), 32'd1);
    chk("draw_wins_p2", 32'(wins_p2), 32'd0);

    // Abort with P1 held, then start+abort together in IDLE
    bus.p1_valid = 1'b1; bus.p1_move = 2'b10;
    tick();
    bus.p1_valid = 1'b0;
    chk("ab_p1_held", 32'(bus.p1_ready), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_core_reset", 32'(bus.core_reset), 32'd1);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_rounds", 32'(rounds), 32'd2);
    chk("ab_result", 32'(result), 32'd2);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_core_reset", 32'(bus.core_reset), 32'd1);
    do_start(4'b0000);
    chk("ab_held_dropped", 32'(bus.p1_ready), 32'd1);

    // Only P1 moves
    bus.p1_valid = 1'b1; bus.p1_move = 2'b01;
    tick();
    bus.p1_valid = 1'b0;
    saw_done = 1'b0;
`ifdef MORRA_TIMEOUT_EN
    for (int i = 0; i < 20 && !saw_done; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("to_done_seen", 32'(saw_done), 32'd1);
    chk("to_result", 32'(result), 32'd1);
    chk("to_core_reset", 32'(bus.core_reset), 32'd1);
    tick();
    do_start(4'b0000);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("wait_no_done", 32'(saw_done), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_p2_ready", 32'(bus.p2_ready), 32'd1);
`endif

    // Reset mid-COLLECT
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_p1_ready", 32'(bus.p1_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
